// File: rtl/button_repeat_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: button bit map,
// per-channel FSM encoding, default timing and counter sizing.
package button_repeat_conditioner_pkg;

  localparam int BTN_LEFT  = 32'd0;
  localparam int BTN_RIGHT = 32'd1;
  localparam int BTN_UP    = 32'd2;
  localparam int BTN_DOWN  = 32'd3;

  localparam int DEFAULT_N_BTN           = 32'd4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 32'd650000;
  localparam int DEFAULT_HOLD_CYCLES     = 32'd32500000;
  localparam int DEFAULT_REPEAT_CYCLES   = 32'd6500000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_e;

  // Width of a counter that must hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(max_val + 32'sd1);
    end
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce counter, and the press/repeat FSM
// that emits single-cycle strobes while the debounced level is held high.
module button_channel
  import button_repeat_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int DW   = cnt_width(DEBOUNCE_CYCLES - 32'sd1);
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = cnt_width(RMAX - 32'sd1);

  localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [RW-1:0] HOLD_LOAD   = RW'(HOLD_CYCLES - 32'sd1);
  localparam logic [RW-1:0] REPEAT_LOAD = RW'(REPEAT_CYCLES - 32'sd1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          pulse_r;
  logic [DW-1:0] dcnt_r;
  logic [RW-1:0] rcnt_r;
  chan_state_e   state_r;

  logic differ_s;
  logic accept_s;
  logic rise_s;
  logic fall_s;

  // Decide whether this sample completes a stable run and flips the level.
  always_comb begin
    differ_s = sync2_r ^ level_r;
    if (differ_s && (dcnt_r == DCNT_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    rise_s = accept_s & ~level_r;
    fall_s = accept_s & level_r;
  end

  // Two-stage synchronizer for the raw asynchronous button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: count consecutive disagreeing samples, toggle the level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      dcnt_r  <= '0;
    end else if (accept_s) begin
      level_r <= ~level_r;
      dcnt_r  <= '0;
    end else if (differ_s) begin
      level_r <= level_r;
      dcnt_r  <= dcnt_r + DW'(1);
    end else begin
      level_r <= level_r;
      dcnt_r  <= '0;
    end
  end

  // Press/repeat FSM; a falling level in the same cycle as rcnt expiry suppresses the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rcnt_r  <= '0;
      pulse_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r <= ST_ARMED;
            rcnt_r  <= HOLD_LOAD;
            pulse_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            rcnt_r  <= '0;
            pulse_r <= 1'b0;
          end
        end
        ST_ARMED, ST_REPEAT: begin
          if (fall_s) begin
            state_r <= ST_IDLE;
            rcnt_r  <= '0;
            pulse_r <= 1'b0;
          end else if (rcnt_r == '0) begin
            state_r <= ST_REPEAT;
            rcnt_r  <= REPEAT_LOAD;
            pulse_r <= 1'b1;
          end else begin
            state_r <= state_r;
            rcnt_r  <= rcnt_r - RW'(1);
            pulse_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          rcnt_r  <= '0;
          pulse_r <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;

endmodule

// File: rtl/button_repeat_conditioner.sv
// Pushbutton conditioner for the camera controls: one independent
// synchronize/debounce/auto-repeat channel per button.
module button_repeat_conditioner
  import button_repeat_conditioner_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  // Hold/repeat of at least 2 keeps a low cycle between strobes for the downstream edge detector.
  if (DEBOUNCE_CYCLES < 32'sd1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 32'sd2) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 32'sd2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_in[i]),
      .level (btn_level[i]),
      .pulse (btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Self-checking bench: directed scenarios with fixed expected edges plus
// randomized button activity compared to a window/schedule reference model.
module tb_button_repeat_conditioner;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int H  = 10;
  localparam int R  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [NB-1:0] m_d1, m_d2, m_level, m_pulse;
  logic [D-1:0]  m_win [NB];
  int            t_rise [NB];
  int            cyc = 0;

  always #5 clk = ~clk;

  button_repeat_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  // Model: a level flips once the last D synchronized samples all oppose it;
  // pulses fall at rise time, rise+H, rise+H+k*R while the level stays high.
  initial begin : model
    logic samp;
    logic [D-1:0] opp;
    int age;
    m_d1 = '0; m_d2 = '0; m_level = '0; m_pulse = '0;
    for (int c = 0; c < NB; c++) begin
      m_win[c] = '0;
      t_rise[c] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_d1 = '0; m_d2 = '0; m_level = '0; m_pulse = '0;
        for (int c = 0; c < NB; c++) m_win[c] = '0;
      end else begin
        cyc++;
        for (int c = 0; c < NB; c++) begin
          samp     = m_d2[c];
          m_d2[c]  = m_d1[c];
          m_d1[c]  = btn_in[c];
          m_win[c] = {m_win[c][D-2:0], samp};
          opp      = m_level[c] ? {D{1'b0}} : {D{1'b1}};
          if (m_win[c] == opp) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) t_rise[c] = cyc;
          end
          if (m_level[c]) begin
            age = cyc - t_rise[c];
            m_pulse[c] = (age == 0) || (age >= H && ((age - H) % R) == 0);
          end else begin
            m_pulse[c] = 1'b0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    btn_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (btn_level !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_level got=%b want=0000", btn_level);
    end
    n_checks++;
    if (btn_pulse !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_pulse got=%b want=0000", btn_pulse);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_press();
    logic exp_p, exp_l;
    btn_in = 4'b0001;
    for (int e = 0; e < 26; e++) begin
      @(negedge clk);
      exp_p = (e == 5) || (e == 15) || (e == 18) || (e == 21) || (e == 24);
      exp_l = (e >= 5);
      n_checks++;
      if (btn_pulse[0] !== exp_p) begin
        n_fails++;
        $display("FAIL press_pulse edge=%0d got=%b want=%b", e, btn_pulse[0], exp_p);
      end
      n_checks++;
      if (btn_level[0] !== exp_l) begin
        n_fails++;
        $display("FAIL press_level edge=%0d got=%b want=%b", e, btn_level[0], exp_l);
      end
      n_checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse) begin
        n_fails++;
        $display("FAIL press_model edge=%0d got l=%b p=%b want l=%b p=%b", e, btn_level, btn_pulse, m_level, m_pulse);
      end
    end
    btn_in = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce();
    int npulse = 0;
    btn_in = 4'b0010;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      if (e == 2) btn_in = 4'b0000;
      n_checks++;
      if (btn_level[1] !== 1'b0 || btn_pulse[1] !== 1'b0) begin
        n_fails++;
        $display("FAIL bounce_short edge=%0d got l=%b p=%b want l=0 p=0", e, btn_level[1], btn_pulse[1]);
      end
    end
    btn_in = 4'b0010;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      if (e == 3) btn_in = 4'b0000;
      if (btn_pulse[1] === 1'b1) npulse++;
      n_checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse) begin
        n_fails++;
        $display("FAIL bounce_model edge=%0d got l=%b p=%b want l=%b p=%b", e, btn_level, btn_pulse, m_level, m_pulse);
      end
    end
    n_checks++;
    if (npulse != 1) begin
      n_fails++;
      $display("FAIL bounce_burst_count got=%0d want=1", npulse);
    end
  endtask

  task automatic test_release();
    logic exp_p, exp_l;
    btn_in = 4'b0001;
    for (int e = 0; e < 32; e++) begin
      @(negedge clk);
      exp_p = (e == 5) || (e == 15) || (e == 18) || (e == 21);
      exp_l = (e >= 5) && (e <= 23);
      n_checks++;
      if (btn_pulse[0] !== exp_p || btn_level[0] !== exp_l) begin
        n_fails++;
        $display("FAIL release edge=%0d got l=%b p=%b want l=%b p=%b", e, btn_level[0], btn_pulse[0], exp_l, exp_p);
      end
      if (e == 18) btn_in = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic exp_p;
    btn_in = 4'b0001;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (btn_level !== 4'b0000 || btn_pulse !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_async got l=%b p=%b want l=0000 p=0000", btn_level, btn_pulse);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 21; e++) begin
      @(negedge clk);
      exp_p = (e == 5) || (e == 15) || (e == 18);
      n_checks++;
      if (btn_pulse[0] !== exp_p || btn_level[0] !== (e >= 5)) begin
        n_fails++;
        $display("FAIL reset_restart edge=%0d got l=%b p=%b want l=%b p=%b", e, btn_level[0], btn_pulse[0], (e >= 5), exp_p);
      end
    end
    btn_in = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic p0 [30];
    btn_in = 4'b1001;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      p0[e] = btn_pulse[0];
      if (e == 1) btn_in = 4'b1011;
      n_checks++;
      if (btn_pulse[3] !== btn_pulse[0] || btn_pulse[2] !== 1'b0 || btn_level[2] !== 1'b0) begin
        n_fails++;
        $display("FAIL simul_03 edge=%0d got p=%b l=%b", e, btn_pulse, btn_level);
      end
      if (e >= 2) begin
        n_checks++;
        if (btn_pulse[1] !== p0[e-2]) begin
          n_fails++;
          $display("FAIL simul_1 edge=%0d got=%b want=%b", e, btn_pulse[1], p0[e-2]);
        end
      end
      n_checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse) begin
        n_fails++;
        $display("FAIL simul_model edge=%0d got l=%b p=%b want l=%b p=%b", e, btn_level, btn_pulse, m_level, m_pulse);
      end
    end
    btn_in = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int remain [NB];
    for (int c = 0; c < NB; c++) remain[c] = $urandom_range(1, 8);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      n_checks++;
      if (btn_level !== m_level || btn_pulse !== m_pulse) begin
        n_fails++;
        $display("FAIL random_model n=%0d got l=%b p=%b want l=%b p=%b", n, btn_level, btn_pulse, m_level, m_pulse);
      end
      if (n == 700) rst_n = 1'b0;
      if (n == 703) rst_n = 1'b1;
      for (int c = 0; c < NB; c++) begin
        remain[c]--;
        if (remain[c] <= 0) begin
          btn_in[c] = ~btn_in[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
        end
      end
    end
  endtask

  initial begin : main
    rst_n  = 1'b0;
    btn_in = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_reset_mid_repeat();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
